// File: rtl/slave_tx_ctrl_pkg.sv
// Shared definitions for the I2C slave transmit controller.
//   tx_state_t     : controller state encoding
//   BYTE_BITS      : data bits per byte on the wire
//   CNT_W          : bit-counter width
//   UNDERFLOW_BYTE : value presented by an empty TX FIFO
package slave_tx_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SHIFT     = 3'd2,
    ACK_WAIT  = 3'd3,
    ACK_CHECK = 3'd4
  } tx_state_t;

  localparam int          BYTE_BITS      = 8;
  localparam int          CNT_W          = 4;
  localparam logic [7:0]  UNDERFLOW_BYTE = 8'hFF;

endpackage

// File: rtl/slave_tx_ctrl_flex_counter.sv
// Generic up-counter with synchronous clear and programmable rollover.
//   clk, n_rst    : clock / async active-low reset
//   clear         : synchronous clear to 0 (wins over count_enable)
//   count_enable  : advance by one
//   rollover_val  : count after which the next enable wraps to 1
//   count_out     : current count
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out
);

  logic [NUM_CNT_BITS-1:0] next_count;

  always_comb begin
    next_count = count_out;
    if (clear)
      next_count = '0;
    else if (count_enable)
      next_count = (count_out == rollover_val) ? NUM_CNT_BITS'(1)
                                               : count_out + 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) count_out <= '0;
    else        count_out <= next_count;
  end

endmodule

// File: rtl/slave_tx_ctrl.sv
// I2C slave transmit controller: loads bytes from the TX FIFO into the
// parallel-to-serial register, shifts them out MSB first on SCL falling
// edges, then releases SDA and samples the master ACK/NACK.
//   clk, n_rst              : clock / async active-low reset
//   rising_edge/falling_edge: synchronized SCL edge pulses
//   start_found/stop_found  : bus condition pulses, abort to IDLE
//   tx_start                : read address ACKed, begin transmitting
//   sda_in                  : synchronized SDA level
//   fifo_empty              : TX FIFO has no byte
//   load_data, fifo_rd      : registered load / pop strobes
//   tx_enable, sda_drive    : shift enable / SDA output enable
//   tx_underflow            : registered pulse, load from empty FIFO
//   ack_rcvd, nack_rcvd     : registered pulses, master response
//   tx_busy                 : not IDLE
module slave_tx_ctrl
  import slave_tx_ctrl_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic rising_edge,
  input  logic falling_edge,
  input  logic start_found,
  input  logic stop_found,
  input  logic tx_start,
  input  logic sda_in,
  input  logic fifo_empty,
  output logic load_data,
  output logic fifo_rd,
  output logic tx_enable,
  output logic sda_drive,
  output logic tx_underflow,
  output logic ack_rcvd,
  output logic nack_rcvd,
  output logic tx_busy
);

  tx_state_t        state, next_state;
  logic [CNT_W-1:0] bit_cnt;
  logic             abort, rise, sample_now, ack_sample;
  logic             cnt_clear, cnt_en;

  assign abort      = start_found | stop_found;
  // Both edges together should never happen; if it does, the falling edge
  // is the one honoured, so the rise is masked.
  assign rise       = rising_edge & ~falling_edge;
  assign sample_now = (state == ACK_WAIT) & rise & ~abort;
  assign cnt_clear  = (state == LOAD) | abort;
  assign cnt_en     = (state == SHIFT) & falling_edge;

  flex_counter #(
    .NUM_CNT_BITS (CNT_W)
  ) u_bit_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_enable (cnt_en),
    .rollover_val (CNT_W'(BYTE_BITS)),
    .count_out    (bit_cnt)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE:      if (tx_start) next_state = LOAD;
        LOAD:      next_state = SHIFT;
        // The falling edge that ends bit 8 is the one seen with count 7.
        SHIFT:     if (falling_edge && bit_cnt == CNT_W'(BYTE_BITS - 1))
                     next_state = ACK_WAIT;
        ACK_WAIT:  if (rise) next_state = ACK_CHECK;
        ACK_CHECK: if (falling_edge) next_state = ack_sample ? LOAD : IDLE;
        default:   next_state = IDLE;
      endcase
    end
  end

  // Strobes are registered off next_state so they line up with the LOAD
  // cycle itself. LOAD never persists, so each entry gives one pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      load_data    <= 1'b0;
      fifo_rd      <= 1'b0;
      tx_underflow <= 1'b0;
      ack_rcvd     <= 1'b0;
      nack_rcvd    <= 1'b0;
      ack_sample   <= 1'b0;
    end else begin
      load_data    <= (next_state == LOAD);
      fifo_rd      <= (next_state == LOAD) & ~fifo_empty;
      tx_underflow <= (next_state == LOAD) &  fifo_empty;
      ack_rcvd     <= sample_now & ~sda_in;
      nack_rcvd    <= sample_now &  sda_in;
      if (sample_now) ack_sample <= ~sda_in;  // 1 = master ACKed
    end
  end

  // LOAD keeps driving so SDA holds the previous register bit for a cycle.
  assign tx_enable = (state == SHIFT);
  assign sda_drive = (state == LOAD) | (state == SHIFT);
  assign tx_busy   = (state != IDLE);

endmodule
